// File: rtl/sdp_memory.sv
// Simple dual-port synchronous RAM with one write port and one registered read port on a single clock.
// Reads are read-first, and out-of-range accesses are dropped (write) or return zero (read).
module sdp_memory #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int MEM_SIZE   = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] write_address,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  read_en,
    input  logic [ADDR_WIDTH-1:0] read_address,
    output logic [DATA_WIDTH-1:0] data_out
);

    localparam int IDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
    localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH + 1)'(MEM_SIZE);

    // Zero contents at power-up; rst_n never touches the array.
    logic [DATA_WIDTH-1:0] mem_q [MEM_SIZE] = '{default: '0};

    logic                  write_hit;
    logic                  read_in_range;
    logic [DATA_WIDTH-1:0] data_out_d;
    logic [DATA_WIDTH-1:0] data_out_q;

    always_comb begin
        write_hit     = rst_n && write_en && ({1'b0, write_address} < MEM_LIMIT);
        read_in_range = ({1'b0, read_address} < MEM_LIMIT);
        data_out_d    = data_out_q;
        // The array is sampled before this edge's write lands, which gives read-first behaviour.
        if (read_en) begin
            data_out_d = read_in_range ? mem_q[read_address[IDX_W-1:0]] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_out_q <= '0;
        end else begin
            data_out_q <= data_out_d;
        end
    end

    // NOTE: the storage array has no reset branch, so it can map onto block RAM and survives rst_n.
    always_ff @(posedge clk) begin
        if (write_hit) begin
            mem_q[write_address[IDX_W-1:0]] <= data_in;
        end
    end

    assign data_out = data_out_q;

endmodule

// File: tb/tb_sdp_memory.sv
// Directed bench for sdp_memory: a full-depth instance and a 512-word instance share one stimulus,
// so out-of-range behaviour can be compared against in-range behaviour at the same addresses.
module tb_sdp_memory;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       write_en;
    logic [9:0] write_address;
    logic [7:0] data_in;
    logic       read_en;
    logic [9:0] read_address;
    logic [7:0] dout_full;
    logic [7:0] dout_half;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sdp_memory #(.DATA_WIDTH(8), .ADDR_WIDTH(10), .MEM_SIZE(1024)) u_full (
        .clk(clk), .rst_n(rst_n), .write_en(write_en), .write_address(write_address),
        .data_in(data_in), .read_en(read_en), .read_address(read_address), .data_out(dout_full)
    );

    sdp_memory #(.DATA_WIDTH(8), .ADDR_WIDTH(10), .MEM_SIZE(512)) u_half (
        .clk(clk), .rst_n(rst_n), .write_en(write_en), .write_address(write_address),
        .data_in(data_in), .read_en(read_en), .read_address(read_address), .data_out(dout_half)
    );

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        n_tests++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [9:0] a, input logic [7:0] d);
        write_en = 1'b1; write_address = a; data_in = d;
        tick();
        write_en = 1'b0;
    endtask

    task automatic rd(input logic [9:0] a);
        read_en = 1'b1; read_address = a;
        tick();
        read_en = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; write_en = 1'b0; write_address = '0; data_in = '0;
        read_en = 1'b0; read_address = '0;

        // Reset for two cycles, then read power-up contents
        tick(); tick();
        check("reset_full", dout_full, 8'h00);
        check("reset_half", dout_half, 8'h00);
        rst_n = 1'b1;
        rd(10'd5);
        check("powerup_rd5", dout_full, 8'h00);

        // Write/read-back on consecutive edges
        wr(10'd3, 8'hA5);
        wr(10'd4, 8'h3C);
        read_en = 1'b1; read_address = 10'd3;
        tick();
        check("rd3", dout_full, 8'hA5);
        check("rd3_half", dout_half, 8'hA5);
        read_address = 10'd4;
        #2;
        check("no_comb_path", dout_full, 8'hA5);
        tick();
        check("rd4", dout_full, 8'h3C);
        read_en = 1'b0;

        // Hold with read_en low, even while read_address moves
        wr(10'd10, 8'h11);
        rd(10'd10);
        check("rd10", dout_full, 8'h11);
        for (int i = 0; i < 3; i++) begin
            read_address = 10'd3;
            tick();
            check($sformatf("hold%0d", i), dout_full, 8'h11);
        end

        // Read-during-write to the same address returns the old value
        wr(10'd7, 8'h22);
        write_en = 1'b1; write_address = 10'd7; data_in = 8'h99;
        read_en = 1'b1; read_address = 10'd7;
        tick();
        write_en = 1'b0;
        check("rdw_old", dout_full, 8'h22);
        tick();
        check("rdw_new", dout_full, 8'h99);
        read_en = 1'b0;

        // Back-to-back writes to one address: last one wins
        wr(10'd8, 8'h01);
        wr(10'd8, 8'h02);
        rd(10'd8);
        check("last_write_wins", dout_full, 8'h02);

        // Boundaries: full instance stores 1023 and 512, half instance drops both
        wr(10'd0, 8'hFF);
        wr(10'd1023, 8'hEE);
        wr(10'd512, 8'h77);
        rd(10'd0);
        check("rd0_full", dout_full, 8'hFF);
        check("rd0_half", dout_half, 8'hFF);
        rd(10'd1023);
        check("rd1023_full", dout_full, 8'hEE);
        check("rd1023_half_oob", dout_half, 8'h00);
        rd(10'd512);
        check("rd512_full", dout_full, 8'h77);
        check("rd512_half_oob", dout_half, 8'h00);
        rd(10'd0);
        check("rd0_half_unchanged", dout_half, 8'hFF);

        // Reset mid-operation: output clears, a write in the reset cycle is ignored, contents survive
        wr(10'd20, 8'h5A);
        rst_n = 1'b0;
        read_en = 1'b1; read_address = 10'd20;
        write_en = 1'b1; write_address = 10'd21; data_in = 8'h66;
        tick();
        check("midrst_full", dout_full, 8'h00);
        check("midrst_half", dout_half, 8'h00);
        rst_n = 1'b1; write_en = 1'b0;
        tick();
        check("post_rst_rd20", dout_full, 8'h5A);
        check("post_rst_rd20_half", dout_half, 8'h5A);
        read_address = 10'd21;
        tick();
        check("rst_write_ignored", dout_full, 8'h00);
        read_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
